// File: rtl/fip_32_div_seq.sv
// fip_32_div_seq: sequential signed fixed-point divider, z = (x << FRA_BITS) / y.
// Unsigned restoring division on operand magnitudes, one quotient bit per clock,
// 48 iterations, truncation toward zero, overflow and divide-by-zero flags.
// Optional build macro: FIP_DIV_SAT_EN (saturate o_z on overflow / divide-by-zero).
//
// Handshake: i_en is a start request sampled on a rising edge only while o_busy is
// low (FSM in IDLE); requests while busy are dropped, never queued. o_valid is a
// one-clock pulse; o_z, o_ovf and o_dz are valid in that clock and held afterwards
// until the next result. o_busy stays high from the accept edge until DONE -> IDLE.
module fip_32_div_seq #(
    parameter int FRA_BITS = 16
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_en,
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [31:0] o_z,
    output logic        o_valid,
    output logic        o_busy,
    output logic        o_ovf,
    output logic        o_dz,
    output logic [1:0]  dbg_state
);

    localparam int DW = 32 + FRA_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [5:0]      cnt;
    logic            last;      // all iterations done, next BUSY edge registers the result
    logic            sign;
    logic            dz_r;
    logic [32:0]     y_mag;
    logic [32:0]     rem;
    logic [DW-1:0]   dq;        // dividend bits shift out the top, quotient bits shift in
`ifdef FIP_DIV_SAT_EN
    logic            x_neg;
`endif

    logic [32:0]     x_sext;
    logic [32:0]     y_sext;
    logic [32:0]     x_abs;
    logic [32:0]     y_abs;
    logic [33:0]     trial;
    logic            trial_ge;
    logic [32:0]     trial_sub;
    logic            ovf_c;
    logic [31:0]     z_c;

    assign dbg_state = state;

    // Operand magnitudes; |0x80000000| = 0x80000000 fits because of the 33-bit width.
    always_comb begin
        x_sext = {i_x[31], i_x};
        y_sext = {i_y[31], i_y};
        x_abs  = i_x[31] ? (~x_sext + 33'd1) : x_sext;
        y_abs  = i_y[31] ? (~y_sext + 33'd1) : y_sext;
    end

    // One restoring step: shift the next dividend bit into the remainder and try |y|.
    always_comb begin
        trial     = {rem, dq[DW-1]};
        trial_sub = trial[32:0] - y_mag;
        trial_ge  = trial[33] | (trial[32:0] >= y_mag);
    end

    // Final signed quotient, overflow and the value presented on o_z.
    always_comb begin
        ovf_c = 1'b0;
        if (!dz_r) begin
            if (sign) ovf_c = (dq > DW'(33'h0_8000_0000));
            else      ovf_c = (dq > DW'(33'h0_7FFF_FFFF));
        end
        z_c = sign ? (~dq[31:0] + 32'd1) : dq[31:0];
`ifdef FIP_DIV_SAT_EN
        if (dz_r)       z_c = x_neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else if (ovf_c) z_c = sign  ? 32'h8000_0000 : 32'h7FFF_FFFF;
`else
        if (dz_r)       z_c = 32'h0000_0000;
`endif
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            last    <= 1'b0;
            sign    <= 1'b0;
            dz_r    <= 1'b0;
            y_mag   <= '0;
            rem     <= '0;
            dq      <= '0;
`ifdef FIP_DIV_SAT_EN
            x_neg   <= 1'b0;
`endif
            o_z     <= 32'd0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
            o_ovf   <= 1'b0;
            o_dz    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_en) begin
                        sign   <= i_x[31] ^ i_y[31];
                        dz_r   <= (i_y == 32'd0);
                        y_mag  <= y_abs;
                        rem    <= '0;
                        dq     <= {x_abs[31:0], {FRA_BITS{1'b0}}};
                        cnt    <= 6'd47;
                        last   <= 1'b0;
`ifdef FIP_DIV_SAT_EN
                        x_neg  <= i_x[31];
`endif
                        o_busy <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (last) begin
                        o_z     <= z_c;
                        o_ovf   <= ovf_c;
                        o_dz    <= dz_r;
                        o_valid <= 1'b1;
                        last    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        rem <= trial_ge ? trial_sub : trial[32:0];
                        dq  <= {dq[DW-2:0], trial_ge};
                        if (cnt == 6'd0) last <= 1'b1;
                        else             cnt  <= cnt - 6'd1;
                    end
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fip_32_div_seq.sv
// Testbench for fip_32_div_seq: directed corner cases, randomized operands,
// busy-ignore and mid-operation reset, checked against a plain-arithmetic model.
module tb_fip_32_div_seq;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [31:0] dx;
    logic [31:0] dy;
    logic [31:0] z;
    logic        valid;
    logic        busy;
    logic        ovf;
    logic        dz;
    logic [1:0]  state;

    int tests;
    int fails;
    logic [33:0] exp_q[$];   // {dz, ovf, z}

    fip_32_div_seq #(.FRA_BITS(16)) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_en      (en),
        .i_x       (dx),
        .i_y       (dy),
        .o_z       (z),
        .o_valid   (valid),
        .o_busy    (busy),
        .o_ovf     (ovf),
        .o_dz      (dz),
        .dbg_state (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // reference: signed arithmetic on 64-bit integers
    function automatic logic [33:0] ref_div(input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ax, ay, mag, q;
        logic neg, r_ovf, r_dz;
        logic [31:0] r_z;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ax  = (sx < 0) ? -sx : sx;
        ay  = (sy < 0) ? -sy : sy;
        neg = x[31] ^ y[31];
        if (ay == 0) begin
            r_dz  = 1'b1;
            r_ovf = 1'b0;
`ifdef FIP_DIV_SAT_EN
            r_z = (sx >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
            r_z = 32'h0;
`endif
        end else begin
            r_dz  = 1'b0;
            mag   = (ax * 65536) / ay;
            r_ovf = neg ? (mag > 64'sd2147483648) : (mag > 64'sd2147483647);
            q     = neg ? -mag : mag;
            r_z   = q[31:0];
`ifdef FIP_DIV_SAT_EN
            if (r_ovf) r_z = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        end
        return {r_dz, r_ovf, r_z};
    endfunction

    // driver: one operation from an idle DUT; optional ignored i_en poke at cycle `poke`
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int poke);
        logic [33:0] e;
        int cyc;
        exp_q.push_back(ref_div(x, y));
        @(negedge clk);
        en = 1'b1; dx = x; dy = y;
        @(negedge clk);
        en = 1'b0; dx = $urandom; dy = $urandom;
        cyc = 0;
        check("busy_after_accept", 32'(busy), 32'd1);
        while (!valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == poke) begin
                en = 1'b1; dx = $urandom; dy = $urandom_range(1, 255);
            end else begin
                en = 1'b0;
            end
        end
        en = 1'b0;
        check("latency", 32'(cyc), 32'd49);
        e = exp_q.pop_front();
        check("z", z, e[31:0]);
        check("ovf", 32'(ovf), 32'(e[32]));
        check("dz", 32'(dz), 32'(e[33]));
        @(negedge clk);
        check("valid_width", 32'(valid), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("z_held", z, e[31:0]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_z"}, z, 32'd0);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
        check({tag, "_dz"}, 32'(dz), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
    endtask

    initial begin
        logic [31:0] rx, ry;
        int seen;
        tests = 0;
        fails = 0;
        rstn = 1'b0; en = 1'b0; dx = '0; dy = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rstn = 1'b1;

        // directed cases
        run_op(32'h0003_0000, 32'h0002_0000, 0);
        run_op(32'hFFFF_0000, 32'h0003_0000, 0);
        run_op(32'h0001_0000, 32'h0000_0000, 0);
        run_op(32'hFFFF_0000, 32'h0000_0000, 0);
        run_op(32'h8000_0000, 32'hFFFF_0000, 0);
        run_op(32'h4000_0000, 32'h0000_0100, 0);
        run_op(32'h8000_0000, 32'h0001_0000, 0);
        run_op(32'h0000_0000, 32'hFFFF_0000, 0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 0);

        // i_en pulse while busy must be ignored
        run_op(32'h0005_0000, 32'h0002_0000, 10);

        // randomized operands, mixing full-range and small divisors
        for (int i = 0; i < 24; i++) begin
            rx = $urandom;
            case ($urandom_range(0, 2))
                0:       ry = $urandom;
                1:       ry = $urandom_range(1, 32'h0003_0000);
                default: ry = 32'(-$signed({1'b0, $urandom_range(1, 32'h0003_0000)}));
            endcase
            run_op(rx, ry, (i % 4 == 0) ? 20 : 0);
        end

        // reset in the middle of an operation: outputs clear, no valid follows
        @(negedge clk);
        en = 1'b1; dx = 32'h0007_0000; dy = 32'h0003_0000;
        @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check_reset_values("abort");
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (valid) seen++;
        end
        check("no_valid_after_abort", 32'(seen), 32'd0);

        // i_en together with reset is dropped
        rstn = 1'b0; en = 1'b1; dx = 32'h0001_0000; dy = 32'h0001_0000;
        @(negedge clk);
        rstn = 1'b1; en = 1'b0;
        @(negedge clk);
        check("en_during_reset_busy", 32'(busy), 32'd0);

        // fresh accept after reset
        run_op(32'h0003_0000, 32'h0002_0000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
